// File: rtl/simdet_pipe.sv
// Pipelined similarity/noise-detection stage: sorts each 3x3 window, forms saturating Nmax/Nmin bounds
// from the middle ranks, and emits the original, zeroed or median pixel. SIMDET_RUNTIME_TH_EN adds per-window thresholds.
`timescale 1ns/1ps
module simdet_pipe #(
    parameter int DATA_W = 8,
    parameter int TH_SMA = 15,
    parameter int TH_SMB = 60,
    parameter int CNT_W  = 16
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [9*DATA_W-1:0]   ivWin,
    input  logic                  iMode,
    input  logic                  iSof,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [DATA_W-1:0]     ovPixel,
    output logic                  oNoisy,
    output logic [DATA_W-1:0]     ovMax,
    output logic [DATA_W-1:0]     ovMin,
    output logic [CNT_W-1:0]      ovNoiseCnt
`ifdef SIMDET_RUNTIME_TH_EN
    ,
    input  logic [DATA_W-1:0]     ivThSMa,
    input  logic [DATA_W-1:0]     ivThSMb
`endif
);

    typedef logic [DATA_W-1:0] pix_t;
    typedef pix_t win_t [9];

    // Odd-even transposition sort split across two stages: passes 0-4, then passes 5-8.
    function automatic win_t oet_half(input win_t v, input logic second);
        win_t r;
        pix_t t;
        int   first;
        int   count;
        r     = v;
        first = second ? 5 : 0;
        count = second ? 4 : 5;
        for (int p = 0; p < 5; p++) begin
            if (p < count) begin
                for (int i = 0; i < 8; i++) begin
                    if ((i % 2) == ((first + p) % 2) && r[i] > r[i+1]) begin
                        t      = r[i];
                        r[i]   = r[i+1];
                        r[i+1] = t;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic pix_t sat_add(input pix_t a, input pix_t b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DATA_W] ? '1 : s[DATA_W-1:0];
    endfunction

    function automatic pix_t sat_sub(input pix_t a, input pix_t b);
        return (a < b) ? '0 : pix_t'(a - b);
    endfunction

    logic adv, sof_xfer;
    win_t win_in;
    pix_t th_a_in, th_b_in;

    assign adv      = !(oValid && !iReady);
    assign oReady   = adv;
    assign sof_xfer = iValid && adv && iSof;

    always_comb begin
        for (int i = 0; i < 9; i++) win_in[i] = ivWin[i*DATA_W +: DATA_W];
    end

`ifdef SIMDET_RUNTIME_TH_EN
    assign th_a_in = ivThSMa;
    assign th_b_in = ivThSMb;
`else
    assign th_a_in = pix_t'(TH_SMA);
    assign th_b_in = pix_t'(TH_SMB);
`endif

    // Datapath registers.
    win_t w1, s2, s3;
    pix_t f1, f2, f3;
    pix_t ta1, ta2, ta3, tb1, tb2, tb3;
    logic m1, m2, m3;

    // NOTE: the datapath carries no reset; only the valid/count-enable bits and visible outputs need one.
    always_ff @(posedge iClk) begin
        if (adv) begin
            w1  <= win_in;
            f1  <= win_in[4];
            m1  <= iMode;
            ta1 <= th_a_in;
            tb1 <= th_b_in;
            s2  <= oet_half(w1, 1'b0);
            f2  <= f1;
            m2  <= m1;
            ta2 <= ta1;
            tb2 <= tb1;
            s3  <= oet_half(s2, 1'b1);
            f3  <= f2;
            m3  <= m2;
            ta3 <= ta2;
            tb3 <= tb2;
        end
    end

    // Stage 4 bounds and decision.
    pix_t maxij, minij, medhi, medlo, nmax, nmin, pix_d;
    logic noisy_d;

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        maxij   = sat_add(s3[5], ta3);
        minij   = sat_sub(s3[3], ta3);
        medhi   = sat_add(s3[4], tb3);
        medlo   = sat_sub(s3[4], tb3);
        nmax    = (maxij < medhi) ? maxij : medhi;
        nmin    = (minij > medlo) ? minij : medlo;
        noisy_d = (f3 >= nmax) || (f3 <= nmin);
        pix_d   = f3;
        if (noisy_d) pix_d = m3 ? s3[4] : '0;
    end

    // Valid bits and count-enable tags; an iSof transfer untags everything already in flight.
    logic v1, v2, v3, c2, c3, c_out;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            c2      <= 1'b0;
            c3      <= 1'b0;
            c_out   <= 1'b0;
            oValid  <= 1'b0;
            ovPixel <= '0;
            oNoisy  <= 1'b0;
            ovMax   <= '0;
            ovMin   <= '0;
        end else if (adv) begin
            v1      <= iValid;
            v2      <= v1;
            v3      <= v2;
            c2      <= !sof_xfer;
            c3      <= c2 && !sof_xfer;
            c_out   <= c3 && !sof_xfer;
            oValid  <= v3;
            ovPixel <= pix_d;
            oNoisy  <= noisy_d;
            ovMax   <= maxij;
            ovMin   <= minij;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            ovNoiseCnt <= '0;
        end else if (sof_xfer) begin
            ovNoiseCnt <= '0;
        end else if (oValid && iReady && oNoisy && c_out && (ovNoiseCnt != '1)) begin
            ovNoiseCnt <= ovNoiseCnt + CNT_W'(1);
        end
    end

endmodule
